// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: microstate codes and strobe encodings.
// Used by the sequencer and by the instruction state encoder upstream.
package ctrl_pkg;

    localparam int ST_W = 7;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_RESET      = 7'd0;
    localparam state_t ST_FETCH_ADDR = 7'd1;
    localparam state_t ST_FETCH_WAIT = 7'd2;
    localparam state_t ST_FETCH_IR   = 7'd3;
    localparam state_t ST_DECODE     = 7'd4;
    localparam state_t ST_ILLEGAL    = 7'd5;
    localparam state_t ST_ALU        = 7'd6;
    localparam state_t ST_STORE_ADDR = 7'd7;
    localparam state_t ST_STORE_WAIT = 7'd8;
    localparam state_t ST_BEQ        = 7'd11;
    localparam state_t ST_BRANCH     = 7'd12;
    localparam state_t ST_LOAD_ADDR  = 7'd13;
    localparam state_t ST_LOAD_WAIT  = 7'd14;
    localparam state_t ST_LOAD_WB    = 7'd15;
    localparam state_t ST_BUS_ERR    = 7'd16;
    localparam state_t ST_ALU_LO     = 7'd17;
    localparam state_t ST_ALU_HI     = 7'd30;

    localparam logic MEM_RW_READ   = 1'b1;
    localparam logic MEM_RW_WRITE  = 1'b0;
    localparam logic PC_SRC_SEQ    = 1'b0;
    localparam logic PC_SRC_BRANCH = 1'b1;
    localparam logic RF_SRC_ALU    = 1'b0;
    localparam logic RF_SRC_MDR    = 1'b1;

    // ALU execute shares one behaviour across code 6 and the 17..30 block.
    function automatic logic is_alu_code(input state_t c);
        return (c == ST_ALU) || ((c >= ST_ALU_LO) && (c <= ST_ALU_HI));
    endfunction

    // Dispatch codes DECODE may jump to directly.
    function automatic logic is_dispatch_legal(input state_t c);
        return is_alu_code(c) || (c == ST_STORE_ADDR) ||
               (c == ST_BEQ) || (c == ST_LOAD_ADDR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles inside a WAIT state.
// expire flags the last allowed stall cycle while memory is still busy.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear outside WAIT so every wait starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = inc && (cnt_q == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control sequencer: fetch/decode/execute microstates, Moore strobes.
// Optional MEM_TIMEOUT_EN adds a memory-wait watchdog leading to BUS_ERR.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int STATE_W        = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] state_sel,
    input  logic               branch_taken,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic               mar_ld,
    output logic               ir_ld,
    output logic               pc_ld,
    output logic               pc_src,
    output logic               mem_req,
    output logic               mem_rw,
    output logic               mdr_ld,
    output logic               rf_ld,
    output logic               rf_src,
    output logic               illegal_op,
    output logic               bus_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state_q;
    state_t state_d;
    state_t sel;
    logic   tmo_expire;

    assign sel   = state_t'(state_sel);
    assign state = STATE_W'(state_q);

`ifdef MEM_TIMEOUT_EN
    logic in_wait;

    assign in_wait = (state_q == ST_FETCH_WAIT) ||
                     (state_q == ST_STORE_WAIT) ||
                     (state_q == ST_LOAD_WAIT);

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_wait),
        .inc    (in_wait && !mem_ready),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    // Next-state and strobe decode from the current microstate.
    always_comb begin
        state_d    = state_q;
        mar_ld     = 1'b0;
        ir_ld      = 1'b0;
        pc_ld      = 1'b0;
        pc_src     = PC_SRC_SEQ;
        mem_req    = 1'b0;
        mem_rw     = 1'b0;
        mdr_ld     = 1'b0;
        rf_ld      = 1'b0;
        rf_src     = RF_SRC_ALU;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH_ADDR;
            end
            ST_FETCH_ADDR: begin
                mar_ld  = 1'b1;
                state_d = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                mem_req = 1'b1;
                mem_rw  = MEM_RW_READ;
                if (mem_ready) begin
                    state_d = ST_FETCH_IR;
                end else if (tmo_expire) begin
                    state_d = ST_BUS_ERR;
                end
            end
            ST_FETCH_IR: begin
                ir_ld   = 1'b1;
                pc_ld   = 1'b1;
                pc_src  = PC_SRC_SEQ;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = is_dispatch_legal(sel) ? sel : ST_ILLEGAL;
            end
            ST_ILLEGAL: begin
                illegal_op = 1'b1;
                state_d    = ST_FETCH_ADDR;
            end
            ST_STORE_ADDR: begin
                mar_ld  = 1'b1;
                state_d = ST_STORE_WAIT;
            end
            ST_STORE_WAIT: begin
                mem_req = 1'b1;
                mem_rw  = MEM_RW_WRITE;
                if (mem_ready) begin
                    state_d = ST_FETCH_ADDR;
                end else if (tmo_expire) begin
                    state_d = ST_BUS_ERR;
                end
            end
            ST_BEQ: begin
                state_d = branch_taken ? ST_BRANCH : ST_FETCH_ADDR;
            end
            ST_BRANCH: begin
                pc_ld   = 1'b1;
                pc_src  = PC_SRC_BRANCH;
                state_d = ST_FETCH_ADDR;
            end
            ST_LOAD_ADDR: begin
                mar_ld  = 1'b1;
                state_d = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                mem_req = 1'b1;
                mem_rw  = MEM_RW_READ;
                mdr_ld  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_LOAD_WB;
                end else if (tmo_expire) begin
                    state_d = ST_BUS_ERR;
                end
            end
            ST_LOAD_WB: begin
                rf_ld   = 1'b1;
                rf_src  = RF_SRC_MDR;
                state_d = ST_FETCH_ADDR;
            end
`ifdef MEM_TIMEOUT_EN
            ST_BUS_ERR: begin
                bus_err = 1'b1;
                state_d = ST_FETCH_ADDR;
            end
`endif
            default: begin
                if (is_alu_code(state_q)) begin
                    rf_ld   = 1'b1;
                    rf_src  = RF_SRC_ALU;
                    state_d = ST_FETCH_ADDR;
                end else begin
                    state_d = ST_RESET;
                end
            end
        endcase
    end

    // Microstate register; reset forces RESET asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer.
// Timeout scenarios run when MEM_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
module tb_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic [6:0] state_sel;
    logic       branch_taken;
    logic       mem_ready;
    logic [6:0] state;
    logic       mar_ld, ir_ld, pc_ld, pc_src, mem_req, mem_rw;
    logic       mdr_ld, rf_ld, rf_src, illegal_op, bus_err;

    int total = 0;
    int bad   = 0;

    control_sequencer #(
        .STATE_W        (7),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state_sel    (state_sel),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .state        (state),
        .mar_ld       (mar_ld),
        .ir_ld        (ir_ld),
        .pc_ld        (pc_ld),
        .pc_src       (pc_src),
        .mem_req      (mem_req),
        .mem_rw       (mem_rw),
        .mdr_ld       (mdr_ld),
        .rf_ld        (rf_ld),
        .rf_src       (rf_src),
        .illegal_op   (illegal_op),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] strobes();
        return {mar_ld, ir_ld, pc_ld, pc_src, mem_req, mem_rw,
                mdr_ld, rf_ld, rf_src, illegal_op, bus_err};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        state_sel = 7'd6;
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (state !== 7'd0 || strobes() !== 11'd0) begin
                bad++;
                $display("FAIL reset_hold state=%0d strobes=%b want 0/0", state, strobes());
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (state !== 7'd0) begin
            bad++;
            $display("FAIL reset_release state=%0d want 0", state);
        end
        step();
        total++;
        if (state !== 7'd1 || mar_ld !== 1'b1) begin
            bad++;
            $display("FAIL reset_exit state=%0d mar_ld=%b want 1/1", state, mar_ld);
        end
        mem_ready = 1'b0;
        step();
        total++;
        if (state !== 7'd2 || mem_req !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait state=%0d mem_req=%b want 2/1", state, mem_req);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 7'd0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL async_reset state=%0d mem_req=%b want 0/0", state, mem_req);
        end
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step();
    endtask

    task automatic test_alu();
        logic [6:0] exp [6] = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd6, 7'd1};
        state_sel = 7'd6;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (state !== exp[i] || rf_ld !== (exp[i] == 7'd6) ||
                rf_src !== 1'b0) begin
                bad++;
                $display("FAIL alu_trace[%0d] state=%0d rf_ld=%b rf_src=%b want %0d/%b/0",
                         i, state, rf_ld, rf_src, exp[i], exp[i] == 7'd6);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_alu_block();
        state_sel = 7'd30;
        step(); step(); step(); step();
        total++;
        if (state !== 7'd30 || rf_ld !== 1'b1) begin
            bad++;
            $display("FAIL alu_code30 state=%0d rf_ld=%b want 30/1", state, rf_ld);
        end
        step();
        total++;
        if (state !== 7'd1) begin
            bad++;
            $display("FAIL alu_code30_ret state=%0d want 1", state);
        end
    endtask

    task automatic test_store();
        state_sel = 7'd7;
        step(); step(); step(); step();
        total++;
        if (state !== 7'd7 || mar_ld !== 1'b1) begin
            bad++;
            $display("FAIL store_addr state=%0d mar_ld=%b want 7/1", state, mar_ld);
        end
        state_sel = 7'd9;
        step();
        total++;
        if (state !== 7'd8 || mem_req !== 1'b1 || mem_rw !== 1'b0) begin
            bad++;
            $display("FAIL store_wait state=%0d req=%b rw=%b want 8/1/0", state, mem_req, mem_rw);
        end
        step();
        total++;
        if (state !== 7'd1) begin
            bad++;
            $display("FAIL store_ret state=%0d want 1", state);
        end
    endtask

    task automatic test_load();
        state_sel = 7'd13;
        mem_ready = 1'b1;
        step(); step(); step(); step();
        total++;
        if (state !== 7'd13) begin
            bad++;
            $display("FAIL load_addr state=%0d want 13", state);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (state !== 7'd14 || mem_req !== 1'b1 || mem_rw !== 1'b1 ||
                mdr_ld !== 1'b0) begin
                bad++;
                $display("FAIL load_wait[%0d] state=%0d req=%b rw=%b mdr=%b want 14/1/1/0",
                         i, state, mem_req, mem_rw, mdr_ld);
            end
        end
        step();
        mem_ready = 1'b1;
        #1;
        total++;
        if (state !== 7'd14 || mdr_ld !== 1'b1 || mem_req !== 1'b1) begin
            bad++;
            $display("FAIL load_ready state=%0d mdr=%b req=%b want 14/1/1", state, mdr_ld, mem_req);
        end
        step();
        total++;
        if (state !== 7'd15 || rf_ld !== 1'b1 || rf_src !== 1'b1 || mdr_ld !== 1'b0) begin
            bad++;
            $display("FAIL load_wb state=%0d rf_ld=%b rf_src=%b mdr=%b want 15/1/1/0",
                     state, rf_ld, rf_src, mdr_ld);
        end
        step();
        total++;
        if (state !== 7'd1) begin
            bad++;
            $display("FAIL load_ret state=%0d want 1", state);
        end
    endtask

    task automatic test_beq();
        state_sel = 7'd11;
        branch_taken = 1'b1;
        step(); step(); step(); step();
        total++;
        if (state !== 7'd11 || pc_ld !== 1'b0) begin
            bad++;
            $display("FAIL beq_state state=%0d pc_ld=%b want 11/0", state, pc_ld);
        end
        step();
        total++;
        if (state !== 7'd12 || pc_ld !== 1'b1 || pc_src !== 1'b1) begin
            bad++;
            $display("FAIL beq_taken state=%0d pc_ld=%b pc_src=%b want 12/1/1", state, pc_ld, pc_src);
        end
        step();
        branch_taken = 1'b0;
        step(); step(); step(); step();
        total++;
        if (state !== 7'd11) begin
            bad++;
            $display("FAIL beq_nt_state state=%0d want 11", state);
        end
        step();
        total++;
        if (state !== 7'd1) begin
            bad++;
            $display("FAIL beq_not_taken state=%0d want 1", state);
        end
    endtask

    task automatic test_illegal();
        logic [6:0] codes [2] = '{7'd0, 7'd9};
        for (int k = 0; k < 2; k++) begin
            state_sel = codes[k];
            step(); step(); step(); step();
            total++;
            if (state !== 7'd5 || illegal_op !== 1'b1) begin
                bad++;
                $display("FAIL illegal_%0d state=%0d illegal_op=%b want 5/1",
                         codes[k], state, illegal_op);
            end
            step();
            total++;
            if (state !== 7'd1 || illegal_op !== 1'b0) begin
                bad++;
                $display("FAIL illegal_ret_%0d state=%0d illegal_op=%b want 1/0",
                         codes[k], state, illegal_op);
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (state !== 7'd2 || bus_err !== 1'b0) begin
                bad++;
                $display("FAIL tmo_wait[%0d] state=%0d bus_err=%b want 2/0", i, state, bus_err);
            end
        end
        step();
        total++;
        if (state !== 7'd16 || bus_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_buserr state=%0d bus_err=%b want 16/1", state, bus_err);
        end
        step();
        total++;
        if (state !== 7'd1 || bus_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_ret state=%0d bus_err=%b want 1/0", state, bus_err);
        end
        step(); step(); step();
        step();
        mem_ready = 1'b1;
        #1;
        total++;
        if (state !== 7'd2) begin
            bad++;
            $display("FAIL tmo_limit_wait state=%0d want 2", state);
        end
        step();
        total++;
        if (state !== 7'd3 || bus_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_ready_wins state=%0d bus_err=%b want 3/0", state, bus_err);
        end
        step(); step();
    endtask
`else
    task automatic test_no_timeout();
        mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        total++;
        if (state !== 7'd2 || bus_err !== 1'b0 || mem_req !== 1'b1 || mem_rw !== 1'b1) begin
            bad++;
            $display("FAIL long_wait state=%0d bus_err=%b req=%b rw=%b want 2/0/1/1",
                     state, bus_err, mem_req, mem_rw);
        end
        mem_ready = 1'b1;
        step();
        total++;
        if (state !== 7'd3 || ir_ld !== 1'b1 || pc_ld !== 1'b1 || pc_src !== 1'b0) begin
            bad++;
            $display("FAIL fetch_ir state=%0d ir=%b pc_ld=%b pc_src=%b want 3/1/1/0",
                     state, ir_ld, pc_ld, pc_src);
        end
        state_sel = 7'd6;
        step(); step(); step();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_alu_block();
        test_store();
        test_load();
        test_beq();
        test_illegal();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
